// File: rtl/multicycle_control_unit.sv
// Multicycle control unit for the PoliRISC-V core (RV32I / RV64I).
// Sequences fetch, decode and execute and drives the datapath selects and strobes.
module multicycle_control_unit #(
  parameter int DATA_SIZE = 64,
  parameter int BYTE_NUM  = DATA_SIZE / 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [31:0]         instruction,
  input  logic                inst_mem_ack,
  output logic                inst_mem_enable,
  output logic                ir_enable,
  input  logic                data_mem_ack,
  output logic                data_mem_read_enable,
  output logic                data_mem_write_enable,
  output logic [BYTE_NUM-1:0] data_mem_byte_enable,
  input  logic                zero,
  input  logic                negative,
  input  logic                carry_out,
  input  logic                overflow,
  output logic                alua_src,
  output logic                alub_src,
  output logic                aluy_src,
  output logic                alupc_src,
  output logic                pc_src,
  output logic [2:0]          alu_op,
  output logic                sub,
  output logic                arithmetic,
  output logic                alu_word,
  output logic                pc_enable,
  output logic [2:0]          read_data_src,
  output logic [1:0]          write_register_src,
  output logic                write_register_enable,
  output logic                halted,
  output logic                illegal_instruction
);

  localparam bit Is64 = (DATA_SIZE == 64);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpImm32  = 7'b0011011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpReg32  = 7'b0111011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpJal    = 7'b1101111;

  typedef enum logic [3:0] {
    StFetch, StDecode, StRegReg, StRegImm, StLui, StAuipc, StJal, StJalr,
    StBranch, StLoad, StStore, StHalt
  } state_t;

  state_t state_q, state_d, decode_state;
  logic   illegal_q;

  logic [6:0]          opcode;
  logic [2:0]          funct3;
  logic                branch_taken;
  logic [BYTE_NUM-1:0] store_mask;
  logic                unused_bits;

  assign opcode      = instruction[6:0];
  assign funct3      = instruction[14:12];
  assign unused_bits = ^{instruction[31], instruction[29:15], instruction[11:7]};

  always_comb begin
    decode_state = StHalt;
    case (opcode)
      OpLoad:   decode_state = (!Is64 && (funct3 == 3'b011 || funct3 == 3'b110)) ? StHalt : StLoad;
      OpStore:  decode_state = (!Is64 && funct3 == 3'b011) ? StHalt : StStore;
      OpImm:    decode_state = StRegImm;
      OpImm32:  decode_state = Is64 ? StRegImm : StHalt;
      OpReg:    decode_state = StRegReg;
      OpReg32:  decode_state = Is64 ? StRegReg : StHalt;
      OpLui:    decode_state = StLui;
      OpAuipc:  decode_state = StAuipc;
      OpJal:    decode_state = StJal;
      OpJalr:   decode_state = StJalr;
      OpBranch: decode_state = (funct3[2:1] == 2'b01) ? StHalt : StBranch;
      default:  decode_state = StHalt;
    endcase
  end

  always_comb begin
    case (funct3)
      3'b000:  branch_taken = zero;
      3'b001:  branch_taken = ~zero;
      3'b100:  branch_taken = negative ^ overflow;
      3'b101:  branch_taken = ~(negative ^ overflow);
      3'b110:  branch_taken = ~carry_out;
      3'b111:  branch_taken = carry_out;
      default: branch_taken = 1'b0;
    endcase
  end

  // Narrower builds simply drop the upper lanes; SD never reaches StStore there.
  always_comb begin
    case (funct3[1:0])
      2'b00:   store_mask = BYTE_NUM'(8'h01);
      2'b01:   store_mask = BYTE_NUM'(8'h03);
      2'b10:   store_mask = BYTE_NUM'(8'h0F);
      default: store_mask = BYTE_NUM'(8'hFF);
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StFetch;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StDecode && decode_state == StHalt) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_d               = state_q;
    inst_mem_enable       = 1'b0;
    ir_enable             = 1'b0;
    data_mem_read_enable  = 1'b0;
    data_mem_write_enable = 1'b0;
    data_mem_byte_enable  = '0;
    alua_src              = 1'b0;
    alub_src              = 1'b0;
    aluy_src              = 1'b0;
    alupc_src             = 1'b0;
    pc_src                = 1'b0;
    alu_op                = 3'b000;
    sub                   = 1'b0;
    arithmetic            = 1'b0;
    alu_word              = 1'b0;
    pc_enable             = 1'b0;
    read_data_src         = 3'b000;
    write_register_src    = 2'b00;
    write_register_enable = 1'b0;
    halted                = 1'b0;
    illegal_instruction   = 1'b0;
    // Outputs are forced quiet while reset is held, whatever the current state.
    if (!reset) begin
      illegal_instruction = illegal_q;
      unique case (state_q)
        StFetch: begin
          inst_mem_enable = 1'b1;
          if (inst_mem_ack) begin
            ir_enable = 1'b1;
            state_d   = StDecode;
          end
        end
        StDecode: state_d = decode_state;
        StRegReg, StRegImm: begin
          alub_src              = (state_q == StRegReg);
          aluy_src              = opcode[3];
          alu_op                = funct3;
          arithmetic            = instruction[30];
          sub                   = (state_q == StRegReg) & instruction[30];
          alu_word              = Is64 & opcode[3];
          write_register_src    = 2'b10;
          write_register_enable = 1'b1;
          pc_enable             = 1'b1;
          state_d               = StFetch;
        end
        StLui, StAuipc: begin
          aluy_src              = (state_q == StLui);
          alua_src              = (state_q == StAuipc);
          write_register_src    = 2'b10;
          write_register_enable = 1'b1;
          pc_enable             = 1'b1;
          state_d               = StFetch;
        end
        StJal, StJalr: begin
          pc_src                = 1'b1;
          alupc_src             = (state_q == StJalr);
          write_register_src    = 2'b01;
          write_register_enable = 1'b1;
          pc_enable             = 1'b1;
          state_d               = StFetch;
        end
        StBranch: begin
          alub_src  = 1'b1;
          sub       = 1'b1;
          pc_src    = branch_taken;
          pc_enable = 1'b1;
          state_d   = StFetch;
        end
        StLoad: begin
          data_mem_read_enable = 1'b1;
          data_mem_byte_enable = '1;
          read_data_src        = {~funct3[2], funct3[1:0]};
          if (data_mem_ack) begin
            write_register_enable = 1'b1;
            pc_enable             = 1'b1;
            state_d               = StFetch;
          end
        end
        StStore: begin
          data_mem_write_enable = 1'b1;
          data_mem_byte_enable  = store_mask;
          if (data_mem_ack) begin
            pc_enable = 1'b1;
            state_d   = StFetch;
          end
        end
        StHalt:  halted = 1'b1;
        default: state_d = StFetch;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: instruction-level reference model
// queues expected per-cycle outputs; a negedge monitor compares them against the DUT.
module tb_multicycle_control_unit;

  typedef struct packed {
    logic       ime, ire, rde, wme;
    logic [7:0] be;
    logic       alua, alub, aluy, alupc, pcs;
    logic [2:0] op;
    logic       sub, ar, aw, pce;
    logic [2:0] rds;
    logic [1:0] wrs;
    logic       wre, hlt, ill;
  } outs_t;

  typedef struct {
    bit          ds64;
    outs_t       exp;
    logic [63:0] tag;
  } sb_t;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpImm32  = 7'b0011011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpReg32  = 7'b0111011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpJal    = 7'b1101111;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instruction = '0;
  logic        inst_mem_ack = 1'b0, data_mem_ack = 1'b0;
  logic        zero = 1'b0, negative = 1'b0, carry_out = 1'b0, overflow = 1'b0;

  always #5 clock = ~clock;

  logic       ime64, ire64, rde64, wme64, alua64, alub64, aluy64, alupc64, pcs64;
  logic       sub64, ar64, aw64, pce64, wre64, hlt64, ill64;
  logic [7:0] be64;
  logic [2:0] op64, rds64;
  logic [1:0] wrs64;
  logic       ime32, ire32, rde32, wme32, alua32, alub32, aluy32, alupc32, pcs32;
  logic       sub32, ar32, aw32, pce32, wre32, hlt32, ill32;
  logic [3:0] be32;
  logic [2:0] op32, rds32;
  logic [1:0] wrs32;

  multicycle_control_unit #(.DATA_SIZE(64)) dut64 (
    .clock(clock), .reset(reset), .instruction(instruction),
    .inst_mem_ack(inst_mem_ack), .inst_mem_enable(ime64), .ir_enable(ire64),
    .data_mem_ack(data_mem_ack), .data_mem_read_enable(rde64),
    .data_mem_write_enable(wme64), .data_mem_byte_enable(be64),
    .zero(zero), .negative(negative), .carry_out(carry_out), .overflow(overflow),
    .alua_src(alua64), .alub_src(alub64), .aluy_src(aluy64), .alupc_src(alupc64),
    .pc_src(pcs64), .alu_op(op64), .sub(sub64), .arithmetic(ar64), .alu_word(aw64),
    .pc_enable(pce64), .read_data_src(rds64), .write_register_src(wrs64),
    .write_register_enable(wre64), .halted(hlt64), .illegal_instruction(ill64)
  );

  multicycle_control_unit #(.DATA_SIZE(32)) dut32 (
    .clock(clock), .reset(reset), .instruction(instruction),
    .inst_mem_ack(inst_mem_ack), .inst_mem_enable(ime32), .ir_enable(ire32),
    .data_mem_ack(data_mem_ack), .data_mem_read_enable(rde32),
    .data_mem_write_enable(wme32), .data_mem_byte_enable(be32),
    .zero(zero), .negative(negative), .carry_out(carry_out), .overflow(overflow),
    .alua_src(alua32), .alub_src(alub32), .aluy_src(aluy32), .alupc_src(alupc32),
    .pc_src(pcs32), .alu_op(op32), .sub(sub32), .arithmetic(ar32), .alu_word(aw32),
    .pc_enable(pce32), .read_data_src(rds32), .write_register_src(wrs32),
    .write_register_enable(wre32), .halted(hlt32), .illegal_instruction(ill32)
  );

  outs_t act64, act32;
  assign act64 = {ime64, ire64, rde64, wme64, be64, alua64, alub64, aluy64, alupc64, pcs64,
                  op64, sub64, ar64, aw64, pce64, rds64, wrs64, wre64, hlt64, ill64};
  assign act32 = {ime32, ire32, rde32, wme32, 4'b0, be32, alua32, alub32, aluy32, alupc32,
                  pcs32, op32, sub32, ar32, aw32, pce32, rds32, wrs32, wre32, hlt32, ill32};

  sb_t   sb_q[$];
  sb_t   mon_it;
  outs_t mon_act;
  int    tests = 0;
  int    fails = 0;
  bit    chk64 = 1'b1;

  always @(negedge clock) begin
    if (sb_q.size() > 0) begin
      mon_it  = sb_q.pop_front();
      mon_act = mon_it.ds64 ? act64 : act32;
      tests++;
      if (mon_act !== mon_it.exp) begin
        fails++;
        $display("FAIL %0s ds%0d t=%0t got=%h exp=%h", mon_it.tag, mon_it.ds64 ? 64 : 32,
                 $time, mon_act, mon_it.exp);
      end
    end
  end

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic rnd_flags();
    {zero, negative, carry_out, overflow} = 4'($urandom);
  endtask

  task automatic drive(input logic ia, input logic da, input outs_t e, input logic [63:0] tag);
    sb_t it;
    inst_mem_ack = ia;
    data_mem_ack = da;
    it.ds64 = chk64;
    it.exp  = e;
    it.tag  = tag;
    sb_q.push_back(it);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rnd_flags();
    drive(rb(), rb(), '0, "reset");
    reset = 1'b0;
  endtask

  function automatic bit legal(input logic [31:0] ins, input bit ds64);
    logic [6:0] o;
    logic [2:0] f;
    o = ins[6:0];
    f = ins[14:12];
    case (o)
      OpLoad:   return ds64 || !(f == 3'b011 || f == 3'b110);
      OpStore:  return ds64 || f != 3'b011;
      OpImm32, OpReg32: return ds64;
      OpImm, OpReg, OpLui, OpAuipc, OpJal, OpJalr: return 1'b1;
      OpBranch: return !(f == 3'b010 || f == 3'b011);
      default:  return 1'b0;
    endcase
  endfunction

  // opmode: 0 random operands, 1 equal operands, 2 a=5 b=9
  task automatic run_instr(input logic [31:0] ins, input int fw, input int mw, input int opmode);
    outs_t       e;
    logic [6:0]  o;
    logic [2:0]  f;
    bit          ds64, isreg, isword, taken;
    int          nf, nm, bytes;
    logic [63:0] a, b, d;
    logic        c;
    o      = ins[6:0];
    f      = ins[14:12];
    ds64   = chk64;
    nf     = (fw < 0) ? int'($urandom_range(0, 3)) : fw;
    nm     = (mw < 0) ? int'($urandom_range(0, 4)) : mw;
    instruction = ins;
    for (int i = 0; i <= nf; i++) begin
      e = '0;
      e.ime = 1'b1;
      e.ire = (i == nf);
      rnd_flags();
      drive(i == nf, rb(), e, "fetch");
    end
    rnd_flags();
    drive(rb(), rb(), '0, "decode");
    if (!legal(ins, ds64)) begin
      e = '0;
      e.hlt = 1'b1;
      e.ill = 1'b1;
      repeat (3) begin
        rnd_flags();
        drive(rb(), rb(), e, "halt");
      end
      do_reset();
      return;
    end
    e = '0;
    case (o)
      OpLoad, OpStore: begin
        bytes = 1 << f[1:0];
        for (int i = 0; i <= nm; i++) begin
          e = '0;
          if (o == OpLoad) begin
            e.rde = 1'b1;
            e.be  = ds64 ? 8'hFF : 8'h0F;
            e.rds = {~f[2], f[1:0]};
            e.wre = (i == nm);
          end else begin
            e.wme = 1'b1;
            e.be  = 8'((16'd1 << bytes) - 16'd1);
          end
          e.pce = (i == nm);
          rnd_flags();
          drive(rb(), i == nm, e, "mem");
        end
      end
      OpBranch: begin
        if (opmode == 2) begin
          a = 64'd5;
          b = 64'd9;
        end else begin
          a = {$urandom, $urandom};
          b = (opmode == 1 || $urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
          if (!ds64) begin
            a = {{32{a[31]}}, a[31:0]};
            b = {{32{b[31]}}, b[31:0]};
          end
        end
        {c, d}    = {1'b0, a} + {1'b0, ~b} + 65'd1;
        zero      = (d == 64'd0);
        negative  = d[63];
        carry_out = c;
        overflow  = (a[63] != b[63]) && (d[63] != a[63]);
        case (f)
          3'b000:  taken = (a == b);
          3'b001:  taken = (a != b);
          3'b100:  taken = ($signed(a) < $signed(b));
          3'b101:  taken = ($signed(a) >= $signed(b));
          3'b110:  taken = (a < b);
          default: taken = (a >= b);
        endcase
        e.alub = 1'b1;
        e.sub  = 1'b1;
        e.pce  = 1'b1;
        e.pcs  = taken;
        drive(rb(), rb(), e, "branch");
      end
      default: begin
        isreg  = (o == OpReg || o == OpReg32);
        isword = (o == OpReg32 || o == OpImm32);
        case (o)
          OpLui:   e.aluy = 1'b1;
          OpAuipc: e.alua = 1'b1;
          OpJal, OpJalr: begin
            e.pcs   = 1'b1;
            e.alupc = (o == OpJalr);
          end
          default: begin
            e.alub = isreg;
            e.aluy = isword;
            e.op   = f;
            e.ar   = ins[30];
            e.sub  = isreg & ins[30];
            e.aw   = ds64 & isword;
          end
        endcase
        e.wrs = (o == OpJal || o == OpJalr) ? 2'b01 : 2'b10;
        e.wre = 1'b1;
        e.pce = 1'b1;
        rnd_flags();
        drive(rb(), rb(), e, "exec");
      end
    endcase
  endtask

  task automatic load_reset();
    outs_t e;
    instruction = 32'h0000A183;  // LW x3,0(x1)
    e = '0;
    e.ime = 1'b1;
    e.ire = 1'b1;
    drive(1'b1, 1'b0, e, "fetch");
    drive(1'b0, 1'b0, '0, "decode");
    e = '0;
    e.rde = 1'b1;
    e.be  = chk64 ? 8'hFF : 8'h0F;
    e.rds = 3'b110;
    repeat (2) drive(1'b0, 1'b0, e, "ldwait");
    reset = 1'b1;
    drive(1'b1, 1'b1, '0, "rstload");
    reset = 1'b0;
    e = '0;
    e.ime = 1'b1;
    drive(1'b0, 1'b1, e, "postrst");
    drive(1'b0, 1'b1, e, "postrst");
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 11))
      0: begin
        r[6:0] = OpLoad;
        case ($urandom_range(0, 6))
          0: r[14:12] = 3'b000;
          1: r[14:12] = 3'b001;
          2: r[14:12] = 3'b010;
          3: r[14:12] = 3'b100;
          4: r[14:12] = 3'b101;
          5: r[14:12] = 3'b110;
          default: r[14:12] = 3'b011;
        endcase
      end
      1: begin
        r[6:0] = OpStore;
        r[14]  = 1'b0;
      end
      2:  r[6:0] = OpImm;
      3:  r[6:0] = OpImm32;
      4:  r[6:0] = OpReg;
      5:  r[6:0] = OpReg32;
      6:  r[6:0] = OpLui;
      7:  r[6:0] = OpAuipc;
      8:  r[6:0] = OpJal;
      9:  r[6:0] = OpJalr;
      10: r[6:0] = OpBranch;
      default: if (r[1:0] == 2'b11) r[6:0] = rb() ? 7'b1110011 : 7'b0001111;
    endcase
    return r;
  endfunction

  initial begin
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk64 = 1'b1;
    do_reset();
    run_instr(32'h002081B3, 0, 0, 0);  // ADD
    run_instr(32'h00208063, 0, 0, 1);  // BEQ taken
    run_instr(32'h00208063, 0, 0, 2);  // BEQ not taken
    run_instr(32'h0020E063, 0, 0, 2);  // BLTU taken
    run_instr(32'h00209023, 0, 5, 0);  // SH, ack after 5 waits
    run_instr(32'h002081BB, 0, 0, 0);  // ADDW
    run_instr(32'h0000B183, 1, 2, 0);  // LD
    load_reset();
    run_instr(32'h002081B3, 0, 0, 0);
    for (int i = 0; i < 150; i++) run_instr(rand_instr(), -1, -1, 0);

    chk64 = 1'b0;
    do_reset();
    run_instr(32'h002081BB, 0, 0, 0);  // ADDW is illegal here
    run_instr(32'h0000B183, 0, 0, 0);  // LD is illegal here
    run_instr(32'h00209023, 0, 5, 0);
    load_reset();
    for (int i = 0; i < 150; i++) run_instr(rand_instr(), -1, -1, 0);

    repeat (2) @(negedge clock);
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL drain left=%0d required=0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
